// File: rtl/shift_pkg.sv
// shift_pkg: op encodings and helpers shared by the pipelined shift unit
package shift_pkg;
  localparam logic [2:0] SHOP_SLL = 3'd0;
  localparam logic [2:0] SHOP_SRL = 3'd1;
  localparam logic [2:0] SHOP_SRA = 3'd2;
  localparam logic [2:0] SHOP_ROL = 3'd3;
  localparam logic [2:0] SHOP_ROR = 3'd4;
  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction
  function automatic logic [63:0] bitrev(input logic [63:0] v, input int n);
    logic [63:0] r;
    r = '0;
    for (int i = 0; i < 64; i++)
      if (i < n) r[i] = v[n-1-i];
    return r;
  endfunction
endpackage

// File: rtl/shift_stage.sv
// shift_stage: applies right-shift levels LVL_LO..LVL_HI with zero, sign or rotate fill
module shift_stage
  import shift_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int LVL_LO = 0,
  parameter int LVL_HI = 0
) (
  input  logic [XLEN-1:0]        d,
  input  logic [clog2(XLEN)-1:0] shamt,
  input  logic                   rot,
  input  logic                   arith,
  output logic [XLEN-1:0]        q
);
  always_comb begin
    q = d;
    for (int k = LVL_LO; k <= LVL_HI; k++)
      if (shamt[k]) q = (q >> (1 << k)) | ((rot ? q : {XLEN{arith & q[XLEN-1]}}) << (XLEN - (1 << k)));
  end
endmodule

// File: rtl/shift_unit_pipe.sv
// shift_unit_pipe: pipelined SLL/SRL/SRA/ROL/ROR unit with valid/ready handshakes
module shift_unit_pipe
  import shift_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int STAGES = 2,
  parameter int TAG_W = 5
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [2:0]             in_op,
  input  logic                   in_word,
  input  logic [XLEN-1:0]        in_op1,
  input  logic [clog2(XLEN)-1:0] in_shamt,
  input  logic [TAG_W-1:0]       in_tag,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [XLEN-1:0]        out_result,
  output logic [TAG_W-1:0]       out_tag,
  output logic                   out_illegal
);
  localparam int LG = clog2(XLEN);
  localparam int BASE = LG / STAGES;
  localparam int REM = LG % STAGES;
  typedef struct packed {
    logic rot;
    logic ari;
    logic rev;
    logic wrd;
    logic ill;
    logic [LG-1:0] sh;
    logic [TAG_W-1:0] tag;
  } ctl_t;
  logic [STAGES-1:0] vld, pv, adv;
  logic [XLEN-1:0] dat [STAGES];
  logic [XLEN-1:0] pd [STAGES];
  logic [XLEN-1:0] nd [STAGES];
  ctl_t c [STAGES];
  ctl_t pc [STAGES];
  logic wd, rv;
  logic [63:0] e64;
  logic [XLEN-1:0] x;
  always_comb begin
    wd = XLEN == 64 && in_word;
    rv = in_op == SHOP_SLL || in_op == SHOP_ROL;
    e64 = !wd ? 64'(in_op1) :
          (in_op == SHOP_ROL || in_op == SHOP_ROR) ? {in_op1[31:0], in_op1[31:0]} :
          in_op == SHOP_SRA ? {{32{in_op1[31]}}, in_op1[31:0]} : {32'b0, in_op1[31:0]};
    pv = '0;
    pv[0] = in_valid;
    pd[0] = XLEN'(rv ? bitrev(e64, XLEN) : e64);
    pc[0].rot = in_op == SHOP_ROL || in_op == SHOP_ROR;
    pc[0].ari = in_op == SHOP_SRA;
    pc[0].rev = rv;
    pc[0].wrd = wd;
    pc[0].ill = in_op > SHOP_ROR;
    pc[0].sh = wd ? in_shamt & LG'(31) : in_shamt;
    pc[0].tag = in_tag;
    for (int s = 1; s < STAGES; s++) begin
      pv[s] = vld[s-1];
      pd[s] = dat[s-1];
      pc[s] = c[s-1];
    end
  end
  always_comb begin
    adv = '0;
    for (int s = 0; s < STAGES; s++) adv[s] = out_ready || |(~vld >> s);
  end
  for (genvar g = 0; g < STAGES; g++) begin : g_stage
    localparam int LO = g * BASE + (g < REM ? g : REM);
    localparam int HI = LO + BASE + (g < REM ? 1 : 0) - 1;
    shift_stage #(.XLEN(XLEN), .LVL_LO(LO), .LVL_HI(HI)) u_stage (
      .d(pd[g]),
      .shamt(pc[g].sh),
      .rot(pc[g].rot),
      .arith(pc[g].ari),
      .q(nd[g])
    );
  end
  always_ff @(posedge clk) begin
    for (int s = 0; s < STAGES; s++) begin
      if (rst) begin
        vld[s] <= 1'b0;
        dat[s] <= '0;
        c[s] <= '0;
      end else begin
        if (flush) vld[s] <= 1'b0;
        else if (adv[s]) vld[s] <= pv[s];
        if (adv[s]) begin
          dat[s] <= nd[s];
          c[s] <= pc[s];
        end
      end
    end
  end
  always_comb begin
    x = c[STAGES-1].rev ? XLEN'(bitrev(64'(dat[STAGES-1]), XLEN)) : dat[STAGES-1];
    out_result = c[STAGES-1].ill ? '0 : c[STAGES-1].wrd ? XLEN'({{32{x[31]}}, x[31:0]}) : x;
  end
  assign in_ready = !flush && adv[0];
  assign out_valid = vld[STAGES-1];
  assign out_tag = c[STAGES-1].tag;
  assign out_illegal = c[STAGES-1].ill;
endmodule

// File: tb/tb_shift_unit_pipe.sv
// tb_shift_unit_pipe: directed plus randomized scoreboard check of 32- and 64-bit shift pipes
module tb_shift_unit_pipe;
  logic clk = 0;
  logic rst, flush, in_valid, out_ready, word;
  logic [2:0] op;
  logic [63:0] op1;
  logic [5:0] shamt;
  logic [4:0] tag;
  logic a_ready, a_ov, a_ill, b_ready, b_ov, b_ill;
  logic [31:0] a_res;
  logic [63:0] b_res;
  logic [4:0] a_tag, b_tag;
  int vec = 0, err = 0;
  typedef struct packed {
    logic [63:0] r;
    logic [4:0] t;
    logic il;
  } exp_t;
  exp_t qa[$];
  exp_t qb[$];
  always #5 clk = ~clk;
  shift_unit_pipe #(.XLEN(32), .STAGES(2), .TAG_W(5)) dut_a (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(a_ready),
    .in_op(op), .in_word(word), .in_op1(op1[31:0]), .in_shamt(shamt[4:0]), .in_tag(tag),
    .out_valid(a_ov), .out_ready(out_ready), .out_result(a_res), .out_tag(a_tag), .out_illegal(a_ill)
  );
  shift_unit_pipe #(.XLEN(64), .STAGES(3), .TAG_W(5)) dut_b (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(b_ready),
    .in_op(op), .in_word(word), .in_op1(op1), .in_shamt(shamt), .in_tag(tag),
    .out_valid(b_ov), .out_ready(out_ready), .out_result(b_res), .out_tag(b_tag), .out_illegal(b_ill)
  );
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    vec++;
    if (act !== exp) begin
      err++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask
  function automatic logic [31:0] m32(input logic [2:0] o, input logic [31:0] v, input int n);
    logic signed [31:0] sv;
    sv = v;
    sv = sv >>> n;
    case (o)
      3'd0: return v << n;
      3'd1: return v >> n;
      3'd2: return sv;
      3'd3: return (v << n) | (v >> (32 - n));
      3'd4: return (v >> n) | (v << (32 - n));
      default: return 32'd0;
    endcase
  endfunction
  function automatic logic [63:0] m64(input logic [2:0] o, input logic [63:0] v, input int n);
    logic signed [63:0] sv;
    sv = v;
    sv = sv >>> n;
    case (o)
      3'd0: return v << n;
      3'd1: return v >> n;
      3'd2: return sv;
      3'd3: return (v << n) | (v >> (64 - n));
      3'd4: return (v >> n) | (v << (64 - n));
      default: return 64'd0;
    endcase
  endfunction
  function automatic logic [63:0] ref_fn(input int xl, input logic [2:0] o, input logic w, input logic [63:0] v, input int n);
    logic [31:0] r;
    r = m32(o, v[31:0], n % 32);
    if (o > 3'd4) return 64'd0;
    if (xl == 32) return {32'd0, r};
    if (w) return {{32{r[31]}}, r};
    return m64(o, v, n);
  endfunction
  always @(negedge clk) begin
    if (rst) begin
      qa.delete();
      qb.delete();
    end else begin
      if (a_ov) begin
        if (qa.size() == 0) chk("a_spurious_valid", 64'd1, 64'd0);
        else begin
          chk("a_result", {32'd0, a_res}, qa[0].r);
          chk("a_tag", 64'(a_tag), 64'(qa[0].t));
          chk("a_illegal", 64'(a_ill), 64'(qa[0].il));
          if (out_ready) void'(qa.pop_front());
        end
      end
      if (b_ov) begin
        if (qb.size() == 0) chk("b_spurious_valid", 64'd1, 64'd0);
        else begin
          chk("b_result", b_res, qb[0].r);
          chk("b_tag", 64'(b_tag), 64'(qb[0].t));
          chk("b_illegal", 64'(b_ill), 64'(qb[0].il));
          if (out_ready) void'(qb.pop_front());
        end
      end
      if (in_valid && a_ready) qa.push_back({ref_fn(32, op, word, op1, int'(shamt)), tag, op > 3'd4});
      if (in_valid && b_ready) qb.push_back({ref_fn(64, op, word, op1, int'(shamt)), tag, op > 3'd4});
      if (flush) begin
        qa.delete();
        qb.delete();
      end
    end
  end
  task automatic run(input logic sel, input logic [2:0] o, input logic w, input logic [63:0] v, input int n,
                     input logic [4:0] t, input logic [63:0] exp, input logic il);
    int lat = sel ? 3 : 2;
    chk("model_pin", ref_fn(sel ? 64 : 32, o, w, v, n), exp);
    chk("idle_ready", 64'(sel ? b_ready : a_ready), 64'd1);
    in_valid = 1; op = o; word = w; op1 = v; shamt = 6'(n); tag = t;
    @(posedge clk); #1 in_valid = 0;
    for (int i = 1; i < lat; i++) begin
      @(negedge clk);
      chk("early_valid", 64'(sel ? b_ov : a_ov), 64'd0);
      @(posedge clk); #1;
    end
    @(negedge clk);
    chk("latency_valid", 64'(sel ? b_ov : a_ov), 64'd1);
    chk("direct_result", sel ? b_res : {32'd0, a_res}, exp);
    chk("direct_tag", 64'(sel ? b_tag : a_tag), 64'(t));
    chk("direct_illegal", 64'(sel ? b_ill : a_ill), 64'(il));
    @(posedge clk); #1;
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end
  initial begin
    int nxt, k;
    logic [31:0] held;
    rst = 1; flush = 0; in_valid = 0; out_ready = 1; op = 0; word = 0; op1 = 0; shamt = 0; tag = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_a_valid", 64'(a_ov), 64'd0);
    chk("rst_a_result", 64'(a_res), 64'd0);
    chk("rst_a_tag", 64'(a_tag), 64'd0);
    chk("rst_a_illegal", 64'(a_ill), 64'd0);
    chk("rst_b_valid", 64'(b_ov), 64'd0);
    chk("rst_b_result", b_res, 64'd0);
    @(posedge clk); #1 rst = 0;
    run(0, 3'd2, 0, 64'h8000_0010, 4, 5'd1, 64'hF800_0001, 0);
    run(0, 3'd0, 0, 64'h1, 31, 5'd2, 64'h8000_0000, 0);
    run(0, 3'd1, 0, 64'h8000_0000, 31, 5'd3, 64'h1, 0);
    run(0, 3'd3, 0, 64'h8000_0001, 1, 5'd4, 64'h3, 0);
    run(0, 3'd4, 0, 64'h1, 4, 5'd5, 64'h1000_0000, 0);
    for (int o = 0; o < 5; o++) run(0, 3'(o), 0, 64'h9ABC_DEF1, 0, 5'(o + 6), 64'h9ABC_DEF1, 0);
    run(0, 3'd7, 0, 64'hFFFF_FFFF, 5, 5'd21, 64'h0, 1);
    run(1, 3'd2, 1, 64'h8000_0000, 1, 5'd22, 64'hFFFF_FFFF_C000_0000, 0);
    run(1, 3'd0, 1, 64'h1, 31, 5'd23, 64'hFFFF_FFFF_8000_0000, 0);
    run(1, 3'd4, 0, 64'h1, 63, 5'd24, 64'h2, 0);
    run(1, 3'd1, 1, 64'h0000_000F_8000_0000, 33, 5'd25, 64'h4000_0000, 0);
    out_ready = 0; nxt = 1;
    for (int c = 0; c < 6; c++) begin
      in_valid = 1; op = 3'd1; word = 0; op1 = {$urandom, $urandom}; shamt = 6'($urandom_range(0, 31)); tag = 5'(nxt);
      @(negedge clk);
      if (a_ready) nxt++;
      @(posedge clk); #1;
    end
    @(negedge clk);
    chk("bp_accepted", 64'(nxt - 1), 64'd2);
    chk("bp_ready_low", 64'(a_ready), 64'd0);
    chk("bp_head_tag", 64'(a_tag), 64'd1);
    held = a_res;
    @(posedge clk); #1;
    @(negedge clk);
    chk("bp_stable", 64'(a_res), 64'(held));
    @(posedge clk); #1;
    out_ready = 1; k = 1;
    for (int c = 0; c < 10 && k <= 4; c++) begin
      in_valid = nxt <= 4; tag = 5'(nxt); op1 = {$urandom, $urandom};
      @(negedge clk);
      if (in_valid && a_ready) nxt++;
      chk("bp_back_to_back", 64'(a_ov), 64'd1);
      if (a_ov) begin
        chk("bp_order", 64'(a_tag), 64'(k));
        k++;
      end
      @(posedge clk); #1;
    end
    chk("bp_delivered", 64'(k), 64'd5);
    in_valid = 0;
    repeat (6) @(posedge clk);
    #1 out_ready = 0; in_valid = 1; op = 3'd0; op1 = 64'h5; shamt = 6'd3; tag = 5'd10;
    @(posedge clk); #1 tag = 5'd11;
    @(posedge clk); #1 tag = 5'd12; flush = 1;
    @(negedge clk);
    chk("flush_ready_a", 64'(a_ready), 64'd0);
    chk("flush_ready_b", 64'(b_ready), 64'd0);
    @(posedge clk); #1 flush = 0; in_valid = 0; out_ready = 1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      chk("flush_kill_a", 64'(a_ov), 64'd0);
      chk("flush_kill_b", 64'(b_ov), 64'd0);
      @(posedge clk); #1;
    end
    run(0, 3'd1, 0, 64'hF0, 4, 5'd13, 64'hF, 0);
    repeat (4) @(posedge clk);
    #1 out_ready = 0; in_valid = 1; op = 3'd1; op1 = 64'h1234_5678; shamt = 6'd0; tag = 5'd7;
    @(posedge clk); #1;
    @(posedge clk); #1 in_valid = 0; rst = 1;
    @(negedge clk);
    chk("pre_rst_valid", 64'(a_ov), 64'd1);
    @(negedge clk);
    chk("mid_rst_valid", 64'(a_ov), 64'd0);
    chk("mid_rst_result", 64'(a_res), 64'd0);
    chk("mid_rst_tag", 64'(a_tag), 64'd0);
    chk("mid_rst_illegal", 64'(a_ill), 64'd0);
    chk("mid_rst_b_valid", 64'(b_ov), 64'd0);
    @(posedge clk); #1 rst = 0; out_ready = 1;
    for (int c = 0; c < 500; c++) begin
      in_valid = $urandom_range(0, 9) < 7;
      op = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(5, 7)) : 3'($urandom_range(0, 4));
      word = 1'($urandom);
      op1 = {$urandom, $urandom};
      shamt = ($urandom_range(0, 3) == 0) ? (($urandom_range(0, 1) == 1) ? 6'd63 : 6'd0) : 6'($urandom);
      tag = 5'($urandom);
      out_ready = $urandom_range(0, 9) < 7;
      flush = $urandom_range(0, 39) == 0;
      @(posedge clk); #1;
    end
    flush = 0; in_valid = 0; out_ready = 1;
    repeat (6) @(posedge clk);
    @(negedge clk);
    chk("drain_a", 64'(qa.size()), 64'd0);
    chk("drain_b", 64'(qb.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vec, err);
    $finish;
  end
endmodule

// File: doc/shift_unit_pipe.md
Name: shift_unit_pipe

Overview:
Parametrised, pipelined successor to the single-cycle RV32 shift ALU in the execute stage. It supports XLEN of 32 or 64 and operations SLL, SRL, SRA, ROL and ROR, plus RV64 word (*W) forms. The log2(XLEN) shift levels are split across STAGES register boundaries, with valid/ready handshakes at both ends. It sits beside the main ALU and is fed by the execute-stage decoder with an already-decoded op, shamt and tag.

Parameters:
XLEN, 32, datapath width; legal values 32 or 64
STAGES, 2, pipeline register stages; legal range 1..log2(XLEN); equals the latency
TAG_W, 5, width of the sideband tag (e.g. rd index) carried alongside each result

Ports:
clk  in  1  clock; all state updates on rising edge
rst  in  1  synchronous, active-high reset
flush  in  1  kill all in-flight ops (branch mispredict or trap)
in_valid  in  1  request valid
in_ready  out  1  unit can accept this cycle
in_op  in  3  operation: 000 SLL, 001 SRL, 010 SRA, 011 ROL, 100 ROR, 101-111 illegal
in_word  in  1  *W form; honoured only when XLEN=64, ignored when XLEN=32
in_op1  in  XLEN  operand (rs1)
in_shamt  in  log2(XLEN)  shift amount (rs2 or imm, already selected upstream)
in_tag  in  TAG_W  sideband, returned unchanged
out_valid  out  1  result valid
out_ready  in  1  consumer accepts this cycle
out_result  out  XLEN  shifted result
out_tag  out  TAG_W  tag of out_result
out_illegal  out  1  op was illegal; out_result=0

Behaviour:
- Reset: every stage valid bit=0; out_valid=0, out_result=0, out_tag=0, out_illegal=0. A reset mid-operation drops all in-flight ops at that edge.
- Acceptance: a transfer occurs when in_valid && in_ready. Delivery occurs when out_valid && out_ready.
- Latency: exactly STAGES cycles from accept to out_valid when there is no backpressure. Throughput is 1 op/cycle.
- Stage advance: stage s loads from stage s-1 when stage s is empty, or when stage s is draining this cycle.
- in_ready = !flush && (stage0 empty || stage0 advancing). The ready chain is combinational back from out_ready.
- Backpressure: while out_valid=1 and out_ready=0, out_result, out_tag and out_illegal hold stable. Upstream stages keep filling bubbles; in_ready falls once all STAGES are occupied. Order is strictly FIFO.
- Flush: at the edge, all valid bits clear. Any input presented in the same cycle is not accepted (in_ready=0). Flush has priority over advance. rst has priority over flush.
- Level split: levels k=0..log2(XLEN)-1 (shift by 2^k when shamt[k]=1) are processed lowest first. Each stage gets floor(L/STAGES) levels; the remainder goes one extra level each to the earliest stages.
- Per-level fill, implemented as a right-shift core:
  - SRL: fill with 0.
  - SRA: fill with the operand MSB.
  - ROR: fill with the bits shifted out.
  - SLL and ROL: operand is bit-reversed on entry and the result bit-reversed on exit, using the SRL and ROR fills respectively.
- Word mode (XLEN=64 && in_word):
  - Operand is op1[31:0] and the shift amount is in_shamt[4:0]; in_shamt[5] is ignored.
  - Shifting is 32-bit; SRA fills from bit 31; rotates wrap within 32 bits.
  - Result is sign-extended from bit 31 to 64.
- shamt=0: result equals the operand (word mode: sign-extended low 32 bits).
- Illegal op: the op flows through the pipeline normally with out_illegal=1 and out_result=0.
- Op, word flag, tag and illegal flag are registered alongside the data in every stage.

Decomposition:
- Package shift_pkg holds:
  - op encodings SHOP_SLL/SRL/SRA/ROL/ROR as a 3-bit localparam set;
  - function clog2;
  - function bitrev(XLEN).
- One sub-module, shift_stage, parametrised by XLEN, LVL_LO and LVL_HI. It is combinational and applies levels LVL_LO..LVL_HI with the selected fill.
- shift_unit_pipe instantiates STAGES copies of shift_stage via generate. It owns the pipeline registers, the valid/ready chain, the entry/exit bit reversal and the word-mode sign extension.

Test Plan:
- XLEN=32, STAGES=2, out_ready=1:
  - SRA 0x80000010 by 4 -> 0xF8000001 two cycles after accept.
  - SLL 0x00000001 by 31 -> 0x80000000.
  - SRL 0x80000000 by 31 -> 0x00000001.
- Rotates and zero shift:
  - ROL 0x80000001 by 1 -> 0x00000003.
  - ROR 0x00000001 by 4 -> 0x10000000.
  - Any op with shamt=0 returns the operand.
- Backpressure: hold out_ready=0 and offer 4 back-to-back ops with tags 1-4 -> exactly 2 accepted, then in_ready=0 and out_result stable. Release out_ready -> results arrive in tag order 1,2,3,4, one per cycle.
- Flush: with 2 ops in flight plus in_valid=1, assert flush for 1 cycle -> no out_valid afterwards, the concurrent input is not accepted, and the next op completes with normal latency.
- Illegal op 3'b111, op1=0xFFFFFFFF -> out_illegal=1, out_result=0, tag preserved. Asserting rst mid-stream -> all outputs 0 on the next cycle.
- XLEN=64, STAGES=3:
  - Word-mode SRA of 0x00000000_80000000 by 1 -> 0xFFFFFFFF_C0000000.
  - Word-mode SLL of 0x1 by 31 -> 0xFFFFFFFF_80000000.
  - Full-width ROR of 0x1 by 63 -> 0x00000000_00000002.
